// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Fetch-stage bus bundle covering the instruction-memory request and
//            response channel, the decode-side valid/ready, and redirect.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rdy;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_instr_vld;
    logic        i_instr_rdy;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    // master: the fetch stage itself; slave: memory + decode + branch unit
    modport master (
        output o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld,
        input  i_imem_rdy, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
        input  i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld,
        output i_imem_rdy, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
        output i_redirect, i_redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : RV32I fetch stage. Owns the PC, issues word fetches, buffers
//            in-order responses in a DEPTH-entry FIFO toward decode, and
//            flushes on redirect while dropping stale in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic     i_clk,
    input  wire logic     i_reset,
    instr_fetch_if.master bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(2 * DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [31:0]        c_NOP   = 32'h0000_0013;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_fifo_pc    [DEPTH];
    logic [31:0]        r_fifo_instr [DEPTH];

    logic               w_vld;
    logic               w_handshake;
    logic               w_pop;
    logic               w_req;
    logic               w_accept;
    logic               w_discard;
    logic               w_push;
    logic [c_CNT_W-1:0] w_used;
    logic [31:0]        w_target;

    always_comb begin
        w_vld       = (r_count != '0);
        w_handshake = w_vld & bus.i_instr_rdy;
        w_pop       = w_handshake & ~bus.i_redirect;
        // A head leaving this cycle frees its slot for a new request, which is
        // what allows one instruction per cycle with only two entries.
        w_used      = r_count - c_CNT_W'(w_handshake) + r_inflight - r_drop;
        w_req       = i_reset & ~bus.i_redirect & (r_inflight < c_DEPTH) & (w_used < c_DEPTH);
        w_accept    = w_req & bus.i_imem_rdy;
        w_discard   = bus.i_imem_rvalid & (r_drop != '0);
        w_push      = i_reset & bus.i_imem_rvalid & ~w_discard & ~bus.i_redirect;
        w_target    = bus.i_redirect_pc & 32'hFFFF_FFFC;

        bus.o_imem_req  = w_req;
        bus.o_imem_addr = r_fetch_pc;
        bus.o_instr_vld = w_vld;
        bus.o_instr     = w_vld ? r_fifo_instr[r_rd_ptr] : c_NOP;
        bus.o_pc        = w_vld ? r_fifo_pc[r_rd_ptr] : 32'h0000_0000;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= r_inflight + c_CNT_W'(w_accept) - c_CNT_W'(bus.i_imem_rvalid);
            if (bus.i_redirect) begin
                // Everything still outstanding after this cycle belongs to the old path
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop     <= r_inflight - c_CNT_W'(bus.i_imem_rvalid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_discard) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
            r_fifo_instr[r_wr_ptr] <= bus.i_imem_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst1_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if ifc ();
    instr_fetch_if ifc1 ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst_n), .bus(ifc)
    );
    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
        .i_clk(clk), .i_reset(rst1_n), .bus(ifc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_00A5;
    endfunction

    // Model: requests still owed by memory (with stale marks) and the decode-side queue
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } inf_t;
    inf_t        q_inf[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_fetch_pc    = 32'h0;
    logic [31:0] m_stream_next = 32'h0;
    int          cyc       = 0;
    int          k_lat_min = 1;
    int          k_lat_max = 1;

    bit          d_rst, d_redir, d_rdy, d_irdy;
    logic [31:0] d_tgt;
    logic        s_req, s_vld;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [31:0] pops[$];
    logic [31:0] acc[$];

    task automatic step();
        bit   rv, exp_vld, pop, exp_req;
        int   live;
        inf_t h, n;
        rv = d_rst && (q_inf.size() > 0) && (q_inf[0].due <= cyc);
        rst_n                 = d_rst;
        ifc.i_redirect        = d_redir;
        ifc.i_redirect_pc     = d_tgt;
        ifc.i_imem_rdy        = d_rdy;
        ifc.i_instr_rdy       = d_irdy;
        ifc.i_imem_rvalid     = rv;
        ifc.i_imem_rdata      = rv ? mem_word(q_inf[0].addr) : 32'hDEAD_BEEF;
        exp_vld = q_pc.size() > 0;
        pop     = exp_vld && d_irdy;
        live    = 0;
        foreach (q_inf[i]) if (!q_inf[i].stale) live++;
        exp_req = d_rst && !d_redir && (q_inf.size() < DEPTH) &&
                  (q_pc.size() - int'(pop) + live < DEPTH);
        #1;
        s_req   = ifc.o_imem_req;
        s_addr  = ifc.o_imem_addr;
        s_vld   = ifc.o_instr_vld;
        s_pc    = ifc.o_pc;
        s_instr = ifc.o_instr;
        check("req",   s_req,   exp_req);
        check("addr",  s_addr,  m_fetch_pc);
        check("vld",   s_vld,   exp_vld);
        check("pc",    s_pc,    exp_vld ? q_pc[0] : 32'h0);
        check("instr", s_instr, exp_vld ? mem_word(q_pc[0]) : NOP);
        if (s_req && d_rdy) acc.push_back(s_addr);
        if (s_vld && d_irdy && d_rst && !d_redir) begin
            pops.push_back(s_pc);
            check("stream_pc", s_pc, m_stream_next);
            m_stream_next += 32'd4;
        end
        @(posedge clk);
        if (!d_rst) begin
            q_inf.delete();
            q_pc.delete();
            m_fetch_pc    = 32'h0;
            m_stream_next = 32'h0;
        end else if (d_redir) begin
            if (rv) void'(q_inf.pop_front());
            foreach (q_inf[i]) q_inf[i].stale = 1'b1;
            q_pc.delete();
            m_fetch_pc    = d_tgt & 32'hFFFF_FFFC;
            m_stream_next = m_fetch_pc;
        end else begin
            if (pop) void'(q_pc.pop_front());
            if (rv) begin
                h = q_inf.pop_front();
                if (!h.stale) q_pc.push_back(h.addr);
            end
            if (exp_req && d_rdy) begin
                n.addr  = m_fetch_pc;
                n.stale = 1'b0;
                n.due   = cyc + $urandom_range(k_lat_max, k_lat_min);
                if (q_inf.size() > 0 && n.due <= q_inf[$].due) n.due = q_inf[$].due + 1;
                q_inf.push_back(n);
                m_fetch_pc += 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        d_rst = 1'b0; d_redir = 1'b0;
        step();
        step();
        d_rst = 1'b1;
        pops.delete();
        acc.delete();
    endtask

    logic        v1 [8];
    logic [31:0] p1 [8];
    logic [31:0] acc1[$];
    logic [31:0] pops1[$];
    logic        pend1;
    logic [31:0] pend1_addr;
    int          nstale;

    initial begin
        d_rst = 1'b0; d_redir = 1'b0; d_rdy = 1'b1; d_irdy = 1'b1; d_tgt = 32'h0;
        ifc.i_redirect = 1'b0; ifc.i_redirect_pc = 32'h0; ifc.i_imem_rdy = 1'b0;
        ifc.i_imem_rvalid = 1'b0; ifc.i_imem_rdata = 32'h0; ifc.i_instr_rdy = 1'b0;
        ifc1.i_redirect = 1'b0; ifc1.i_redirect_pc = 32'h0; ifc1.i_imem_rdy = 1'b1;
        ifc1.i_imem_rvalid = 1'b0; ifc1.i_imem_rdata = 32'h0; ifc1.i_instr_rdy = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_req",   ifc.o_imem_req,  1'b0);
        check("reset_vld",   ifc.o_instr_vld, 1'b0);
        check("reset_instr", ifc.o_instr,     NOP);
        check("reset_pc",    ifc.o_pc,        32'h0);
        check("reset_addr",  ifc.o_imem_addr, 32'h0);

        // Streaming with 1-cycle memory: first instruction two cycles after first request
        k_lat_min = 1; k_lat_max = 1; d_rdy = 1'b1; d_irdy = 1'b1;
        do_reset();
        for (int t = 0; t < 8; t++) begin
            step();
            v1[t] = s_vld;
            p1[t] = s_pc;
        end
        check("p1_vld0", v1[0], 1'b0);
        check("p1_vld1", v1[1], 1'b0);
        for (int t = 2; t < 8; t++) begin
            check("p1_vld", v1[t], 1'b1);
            check("p1_pc",  p1[t], 32'(4 * (t - 2)));
        end

        // Decode stalled: exactly DEPTH requests, then resume on ready
        do_reset();
        d_irdy = 1'b0;
        repeat (6) step();
        check("p2_nacc",  acc.size(), 2);
        check("p2_acc0",  acc[0], 32'h0);
        check("p2_acc1",  acc[1], 32'h4);
        check("p2_req",   s_req,  1'b0);
        check("p2_vld",   s_vld,  1'b1);
        check("p2_head",  s_pc,   32'h0);
        d_irdy = 1'b1;
        repeat (6) step();
        check("p2_pop0",  pops[0], 32'h0);
        check("p2_pop1",  pops[1], 32'h4);
        check("p2_acc2",  acc[2],  32'h8);

        // Redirect with two 3-cycle requests in flight
        k_lat_min = 3; k_lat_max = 3;
        do_reset();
        step();
        step();
        d_redir = 1'b1; d_tgt = 32'h0000_0100;
        step();
        d_redir = 1'b0;
        step();
        check("p3_addr", s_addr, 32'h100);
        check("p3_req",  s_req,  1'b0);
        repeat (14) step();
        nstale = 0;
        foreach (pops[i]) if (pops[i] < 32'h100) nstale++;
        check("p3_first", pops[0], 32'h100);
        check("p3_stale", nstale, 0);

        // Misaligned redirect target is forced to word alignment
        k_lat_min = 1; k_lat_max = 1;
        do_reset();
        repeat (5) step();
        d_redir = 1'b1; d_tgt = 32'h0000_0103;
        step();
        d_redir = 1'b0;
        pops.delete();
        step();
        check("p4_addr", s_addr, 32'h100);
        repeat (6) step();
        check("p4_first", pops[0], 32'h100);

        // Random traffic with redirects and a reset pulse mid-stream
        k_lat_min = 1; k_lat_max = 3;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            d_rdy   = ($urandom_range(1, 0) == 1);
            d_irdy  = ($urandom_range(9, 0) < 6);
            d_redir = (i < 700 || i > 760) && ($urandom_range(99, 0) < 3);
            d_tgt   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            d_rst   = (i != 700);
            step();
            if (i == 700) acc.delete();
            if (i == 760) check("p6_restart", acc[0], 32'h0);
        end
        d_rst = 1'b1; d_redir = 1'b0;

        // Top-of-memory wrap on a second instance (RESET_PC = FFFF_FFF8, DEPTH = 4)
        rst1_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst1_n = 1'b1;
        pend1 = 1'b0; pend1_addr = 32'h0;
        for (int t = 0; t < 10; t++) begin
            ifc1.i_imem_rvalid = pend1;
            ifc1.i_imem_rdata  = mem_word(pend1_addr);
            #1;
            if (ifc1.o_instr_vld) begin
                pops1.push_back(ifc1.o_pc);
                check("p5_instr", ifc1.o_instr, mem_word(ifc1.o_pc));
            end
            if (ifc1.o_imem_req) acc1.push_back(ifc1.o_imem_addr);
            pend1      = ifc1.o_imem_req;
            pend1_addr = ifc1.o_imem_addr;
            @(posedge clk); #1;
        end
        check("p5_acc0", acc1[0], 32'hFFFF_FFF8);
        check("p5_acc1", acc1[1], 32'hFFFF_FFFC);
        check("p5_acc2", acc1[2], 32'h0000_0000);
        check("p5_pop0", pops1[0], 32'hFFFF_FFF8);
        check("p5_pop1", pops1[1], 32'hFFFF_FFFC);
        check("p5_pop2", pops1[2], 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
